// File: rtl/dcpu_int_queue.sv
// Interrupt queue for the DCPU core: circular FIFO fed by software INT and hardware
// requests, drained by CPU acknowledge or discarded while IA is zero.
module dcpu_int_queue #(
   parameter int DEPTH = 256,
   parameter int MW    = 16
) (
   input  logic          CORE_CLK,
   input  logic          RESET,
   input  logic          sw_req,
   input  logic [MW-1:0] sw_msg,
   input  logic          hw_req,
   input  logic [MW-1:0] hw_msg,
   input  logic          iaq,
   input  logic          ia_zero,
   input  logic          int_ack,
   output logic          int_valid,
   output logic [MW-1:0] int_msg,
   output logic [8:0]    count,
   output logic          on_fire
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [MW-1:0] mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [8:0]    count_q, count_d;
   logic          on_fire_q, on_fire_d;

   logic          pop;
   logic          sw_acc;
   logic          hw_acc;
   logic [9:0]    free_slots;
   logic [AW-1:0] hw_addr;

   always_comb begin
      int_valid  = (count_q != 9'd0) && !iaq && !ia_zero;
      // Either a delivery (ack) or a silent discard while IA is zero.
      pop        = (count_q != 9'd0) && !iaq && (ia_zero || int_ack);
      free_slots = 10'(DEPTH) - {1'b0, count_q} + {9'd0, pop};
      // sw has priority; hw needs a second slot when sw took the first.
      sw_acc     = sw_req && (free_slots != 10'd0);
      hw_acc     = hw_req && (free_slots > {9'd0, sw_acc});
      hw_addr    = tail_q + AW'(sw_acc);
      head_d     = pop ? head_q + AW'(1) : head_q;
      tail_d     = tail_q + AW'(sw_acc) + AW'(hw_acc);
      count_d    = count_q + 9'(sw_acc) + 9'(hw_acc) - 9'(pop);
      on_fire_d  = on_fire_q | (sw_req & ~sw_acc) | (hw_req & ~hw_acc);
   end

   always_ff @(negedge CORE_CLK or posedge RESET) begin
      if (RESET) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= 9'd0;
         on_fire_q <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         on_fire_q <= on_fire_d;
      end
   end

   // Storage is not reset; count gating makes stale contents unobservable.
   always_ff @(negedge CORE_CLK) begin
      if (sw_acc) mem_q[tail_q]  <= sw_msg;
      if (hw_acc) mem_q[hw_addr] <= hw_msg;
   end

   assign int_msg = mem_q[head_q];
   assign count   = count_q;
   assign on_fire = on_fire_q;

endmodule
